// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared definitions for the multicycle shift sequencer.
//               - Shift operation encodings.
//               - FSM state type.
//               - One-hot step-size select codes used by shift_step.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    // Shift operation encodings, as presented on shift_op_i
    localparam logic [1:0] SH_SLL  = 2'b00;
    localparam logic [1:0] SH_SRL  = 2'b01;
    localparam logic [1:0] SH_SRA  = 2'b10;
    localparam logic [1:0] SH_ROTL = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // One-hot step select: bit 0 = single-bit step, bit 1 = coarse step.
    // All-zero means "no shift this cycle".
    localparam logic [1:0] STEP_SEL_NONE = 2'b00;
    localparam logic [1:0] STEP_SEL_ONE  = 2'b01;
    localparam logic [1:0] STEP_SEL_FAST = 2'b10;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Purely combinational one-step shifter.
//               Shifts value_i by either 1 bit or FAST_STEP bits, according
//               to the one-hot step select. With no select bit set, the value
//               passes through unchanged.
// Ports       : value_i    [WIDTH-1:0] operand for this step
//               op_i       [1:0]       SLL / SRL / SRA / ROTL
//               step_sel_i [1:0]       one-hot: 01 = 1 bit, 10 = FAST_STEP bits
//               value_o    [WIDTH-1:0] shifted value
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FAST_STEP = 4
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [1:0]       op_i,
    input  logic [1:0]       step_sel_i,
    output logic [WIDTH-1:0] value_o
);

    // Keeps the coarse path well-formed even when coarse steps are disabled;
    // in that case the sequencer never selects it.
    localparam int C_FAST_AMT = (FAST_STEP > 0) ? FAST_STEP : 1;

    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] v,
        input logic [1:0]       op,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        case (op)
            SH_SLL:  r = v << amt;
            SH_SRL:  r = v >> amt;
            // The sign comes from the current register value, so repeated
            // steps keep replicating the original MSB.
            SH_SRA:  r = $signed(v) >>> amt;
            default: r = (v << amt) | (v >> (WIDTH - amt));
        endcase
        return r;
    endfunction

    always_comb begin
        value_o = value_i;
        if (step_sel_i == STEP_SEL_FAST) begin
            value_o = shift_by(value_i, op_i, C_FAST_AMT);
        end else if (step_sel_i == STEP_SEL_ONE) begin
            value_o = shift_by(value_i, op_i, 1);
        end
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_ctrl
// Description : Multicycle sequencer for the shift datapath.
//               Performs SLL/SRL/SRA/ROTL of a WIDTH-bit operand by a SHAMT_W-bit
//               amount. It iterates a one-step shifter, taking coarse
//               FAST_STEP-bit steps while the remaining count allows, then
//               single-bit steps.
// Ports       : clk_i       system clock, rising edge
//               reset_i     synchronous, active-high reset
//               start_i     request, sampled in IDLE or DONE
//               shift_op_i  operation (SLL/SRL/SRA/ROTL), sampled with start
//               shamt_i     shift amount, sampled with start
//               data_in_i   operand, sampled with start
//               busy_o      high while shifting
//               done_o      one-cycle pulse, result valid
//               result_o    result, held until the next accepted start
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SHAMT_W   = 5,
    parameter int FAST_STEP = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [1:0]         shift_op_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [WIDTH-1:0]   data_in_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   result_o
);

    localparam bit                 C_FAST_EN  = (FAST_STEP != 0);
    localparam logic [SHAMT_W:0]   C_FAST_CNT = (SHAMT_W + 1)'(FAST_STEP);
    localparam logic [SHAMT_W-1:0] C_FAST_DEC = SHAMT_W'(FAST_STEP);
    localparam logic [SHAMT_W-1:0] C_ONE      = SHAMT_W'(1);

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [1:0]         w_step_sel;
    logic [WIDTH-1:0]   w_stepped;
    logic               w_load;

    // A new request is only accepted outside SHIFT. Accepting in DONE gives
    // back-to-back operation without an idle cycle.
    assign w_load = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Step size for this cycle. It is kept apart from the next-state logic so
    // that the shifter output does not feed back into its own select.
    always_comb begin
        w_step_sel = STEP_SEL_NONE;
        if (state_q == ST_SHIFT) begin
            if (C_FAST_EN && ({1'b0, count_q} >= C_FAST_CNT)) begin
                w_step_sel = STEP_SEL_FAST;
            end else if (count_q != '0) begin
                w_step_sel = STEP_SEL_ONE;
            end
        end
    end

    shift_step #(
        .WIDTH     (WIDTH),
        .FAST_STEP (FAST_STEP)
    ) u_shift_step (
        .value_i    (result_q),
        .op_i       (op_q),
        .step_sel_i (w_step_sel),
        .value_o    (w_stepped)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_load) begin
                    result_d = data_in_i;
                    count_d  = shamt_i;
                    op_d     = shift_op_i;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                case (w_step_sel)
                    STEP_SEL_FAST: begin
                        result_d = w_stepped;
                        count_d  = count_q - C_FAST_DEC;
                    end
                    STEP_SEL_ONE: begin
                        result_d = w_stepped;
                        count_d  = count_q - C_ONE;
                    end
                    default: begin
                        // Count exhausted: this cycle only moves to DONE.
                        state_d  = ST_DONE;
                    end
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            op_q     <= SH_SLL;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == ST_SHIFT);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;

endmodule : shift_seq_ctrl
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_seq_ctrl
// Description : Self-checking bench for shift_seq_ctrl (WIDTH=32, FAST_STEP=4).
//               Expected results come from a bit-serial reference model. They
//               are queued when a request is driven and checked when done_o
//               pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq_ctrl;
    import shift_pkg::*;

    localparam int WIDTH     = 32;
    localparam int SHAMT_W   = 5;
    localparam int FAST_STEP = 4;

    logic               clk = 1'b0;
    logic               reset_i;
    logic               start_i;
    logic [1:0]         shift_op_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic [WIDTH-1:0]   data_in_i;
    logic               busy_o;
    logic               done_o;
    logic [WIDTH-1:0]   result_o;

    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_q[$];

    shift_seq_ctrl #(
        .WIDTH     (WIDTH),
        .SHAMT_W   (SHAMT_W),
        .FAST_STEP (FAST_STEP)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .shift_op_i (shift_op_i),
        .shamt_i    (shamt_i),
        .data_in_i  (data_in_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    // Bit-serial reference model
    function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] op,
                                                   input logic [4:0] s,
                                                   input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = d;
        for (int i = 0; i < int'(s); i++) begin
            case (op)
                SH_SLL:  r = {r[WIDTH-2:0], 1'b0};
                SH_SRL:  r = {1'b0, r[WIDTH-1:1]};
                SH_SRA:  r = {r[WIDTH-1], r[WIDTH-1:1]};
                default: r = {r[WIDTH-2:0], r[WIDTH-1]};
            endcase
        end
        return r;
    endfunction

    function automatic int ref_k(input logic [4:0] s);
        return int'(s) / FAST_STEP + int'(s) % FAST_STEP;
    endfunction

    // Presents a request just before the next rising edge. Returns #1 after
    // the sampling edge. The operands are then scrambled so that any
    // re-sampling would corrupt the result.
    task automatic drive_start(input logic [1:0] op, input logic [4:0] sh,
                               input logic [WIDTH-1:0] d);
        start_i    = 1'b1;
        shift_op_i = op;
        shamt_i    = sh;
        data_in_i  = d;
        exp_q.push_back(ref_shift(op, sh, d));
        @(posedge clk);
        #1;
        start_i    = 1'b0;
        data_in_i  = ~d;
        shamt_i    = ~sh;
        shift_op_i = ~op;
    endtask

    // Counts edges (the sampling edge counts as 1) and busy cycles until
    // done_o is seen on a falling edge.
    task automatic wait_done(output int edges, output int busy_cyc, output bit found);
        edges    = 1;
        busy_cyc = 0;
        found    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                found = 1'b1;
                break;
            end
            if (busy_o === 1'b1) busy_cyc++;
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        start_i = 1'b0;
        shift_op_i = SH_SLL;
        shamt_i = '0;
        data_in_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy_o, done_o} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_flags: busy/done got %b required 00", {busy_o, done_o});
        end
        n_vec++;
        if (result_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_result: got %h required 00000000", result_o);
        end
        reset_i = 1'b0;
    endtask

    task automatic test_table(input string name, input logic [1:0] op,
                              input logic [4:0] sh, input logic [WIDTH-1:0] d,
                              input logic [WIDTH-1:0] req);
        int e, b;
        bit f;
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        drive_start(op, sh, d);
        wait_done(e, b, f);
        exp = exp_q.pop_front();
        n_vec++;
        if (!f) begin
            n_err++;
            $display("FAIL %s_timeout: done never seen, required after %0d edges", name, ref_k(sh) + 2);
            return;
        end
        n_vec++;
        if (result_o !== exp || result_o !== req) begin
            n_err++;
            $display("FAIL %s_result: got %h required %h", name, result_o, req);
        end
        n_vec++;
        if (e != ref_k(sh) + 2) begin
            n_err++;
            $display("FAIL %s_latency: got %0d edges required %0d", name, e, ref_k(sh) + 2);
        end
        n_vec++;
        if (b != ref_k(sh) + 1) begin
            n_err++;
            $display("FAIL %s_busy: got %0d cycles required %0d", name, b, ref_k(sh) + 1);
        end
        // One cycle later: back in IDLE, no done, result held
        @(negedge clk);
        n_vec++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== req) begin
            n_err++;
            $display("FAIL %s_hold: done=%b busy=%b result=%h required 0 0 %h",
                     name, done_o, busy_o, result_o, req);
        end
    endtask

    task automatic test_basic_ops();
        test_table("sll2",   SH_SLL, 5'd2,  32'h0000_0001, 32'h0000_0004);
        test_table("sra31",  SH_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
        test_table("srl31",  SH_SRL, 5'd31, 32'h8000_0000, 32'h0000_0001);
        test_table("zero",   SH_SLL, 5'd0,  32'h0000_003C, 32'h0000_003C);
        test_table("rotl7",  SH_ROTL, 5'd7, 32'hF000_0001, 32'h0000_00F8);
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [4:0] sh;
        logic [WIDTH-1:0] d;
        for (int i = 0; i < 6; i++) begin
            op = 2'($urandom_range(0, 3));
            sh = 5'($urandom_range(0, 31));
            d  = $urandom;
            test_table("rand", op, sh, d, ref_shift(op, sh, d));
        end
    endtask

    task automatic test_back_to_back();
        int e, b;
        bit f;
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        drive_start(SH_ROTL, 5'd4, 32'h8000_0001);
        wait_done(e, b, f);
        exp = exp_q.pop_front();
        n_vec++;
        if (!f || result_o !== exp || exp !== 32'h0000_0018) begin
            n_err++;
            $display("FAIL b2b_first: found=%b got %h required 00000018", f, result_o);
        end
        // Still in the DONE cycle: issue the next request right away
        drive_start(SH_SRL, 5'd1, 32'hFFFF_FFFF);
        wait_done(e, b, f);
        exp = exp_q.pop_front();
        n_vec++;
        if (!f || result_o !== 32'h7FFF_FFFF) begin
            n_err++;
            $display("FAIL b2b_second: found=%b got %h required 7fffffff", f, result_o);
        end
        n_vec++;
        if (e != 3 || b != 2) begin
            n_err++;
            $display("FAIL b2b_latency: got %0d edges %0d busy required 3 edges 2 busy", e, b);
        end
    endtask

    task automatic test_ignore_start();
        int e, b;
        bit f;
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        drive_start(SH_SRL, 5'd20, 32'h8000_0000);
        @(negedge clk);
        n_vec++;
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL ign_busy: got %b required 1", busy_o);
        end
        start_i    = 1'b1;
        shift_op_i = SH_SLL;
        shamt_i    = 5'd5;
        data_in_i  = 32'h0000_000A;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done(e, b, f);
        exp = exp_q.pop_front();
        n_vec++;
        if (!f || result_o !== exp || exp !== 32'h0000_0800) begin
            n_err++;
            $display("FAIL ign_result: found=%b got %h required 00000800", f, result_o);
        end
        n_vec++;
        if (e + 1 != 7 || b + 1 != 6) begin
            n_err++;
            $display("FAIL ign_latency: got %0d edges %0d busy required 7 edges 6 busy", e + 1, b + 1);
        end
    endtask

    task automatic test_reset_abort();
        bit seen_done;
        @(negedge clk);
        drive_start(SH_SLL, 5'd20, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL abort_busy_before: got %b required 1", busy_o);
        end
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        n_vec++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
            n_err++;
            $display("FAIL abort_state: busy=%b done=%b result=%h required 0 0 00000000",
                     busy_o, done_o, result_o);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_o !== 1'b0 || busy_o !== 1'b0) seen_done = 1'b1;
        end
        n_vec++;
        if (seen_done || result_o !== 32'h0) begin
            n_err++;
            $display("FAIL abort_quiet: activity=%b result=%h required 0 00000000", seen_done, result_o);
        end
    endtask

    initial begin
        reset_i    = 1'b1;
        start_i    = 1'b0;
        shift_op_i = SH_SLL;
        shamt_i    = '0;
        data_in_i  = '0;
        test_reset();
        test_basic_ops();
        test_back_to_back();
        test_ignore_start();
        test_random();
        test_reset_abort();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_shift_seq_ctrl
`default_nettype wire
